// File: rtl/mul_ctrl.sv
// RV32M multiply sequencer around an external combinational Booth array: 3-cycle accept-to-result, held until res_ready.
// MUL_REUSE_EN adds a last-product reuse buffer (2-cycle on operand match); flush or RST discards in-flight work.
module mul_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [DATA_WIDTH-1:0]   req_rs1,
    input  logic [DATA_WIDTH-1:0]   req_rs2,
    input  logic [4:0]              req_tag,
    input  logic                    flush,
    output logic [DATA_WIDTH-1:0]   mul_a,
    output logic [DATA_WIDTH-1:0]   mul_b,
    input  logic [2*DATA_WIDTH-1:0] mul_p,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_WIDTH-1:0]   res_data,
    output logic [4:0]              res_tag,
    output logic                    busy
);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {IDLE, MULT, CORR, DONE} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              op_q;
    logic [4:0]              tag_q;
    logic [2*DATA_WIDTH-1:0] prod_q;
    logic [DATA_WIDTH-1:0]   hi;
    logic [DATA_WIDTH-1:0]   corr_res;
    logic                    accept;
    logic                    reuse_hit;

`ifdef MUL_REUSE_EN
    logic                    buf_vld;
    logic [DATA_WIDTH-1:0]   buf_a;
    logic [DATA_WIDTH-1:0]   buf_b;
    logic [2*DATA_WIDTH-1:0] buf_p;

    assign reuse_hit = buf_vld && (req_rs1 == buf_a) && (req_rs2 == buf_b);

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            buf_vld <= 1'b0;
            buf_a   <= '0;
            buf_b   <= '0;
            buf_p   <= '0;
        end else if (state_q == MULT) begin
            buf_vld <= 1'b1;
            buf_a   <= mul_a;
            buf_b   <= mul_b;
            buf_p   <= mul_p;
        end
    end
`else
    assign reuse_hit = 1'b0;
`endif

    assign accept = req_valid && req_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) state_d = reuse_hit ? CORR : MULT;
                MULT: state_d = CORR;
                CORR: state_d = DONE;
                DONE: begin
                    if (accept) begin
                        state_d = reuse_hit ? CORR : MULT;
                    end else if (res_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = !RST && !flush && ((state_q == IDLE) || ((state_q == DONE) && res_ready));
        res_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // The array is signed x signed; unsigned views are recovered by adding the sign-weighted operands to the high word.
    assign hi = prod_q[2*DATA_WIDTH-1:DATA_WIDTH];

    always_comb begin
        corr_res = prod_q[DATA_WIDTH-1:0];
        case (op_q)
            OP_MULH:   corr_res = hi;
            OP_MULHSU: corr_res = hi + (mul_b[DATA_WIDTH-1] ? mul_a : '0);
            OP_MULHU:  corr_res = hi + (mul_a[DATA_WIDTH-1] ? mul_b : '0)
                                     + (mul_b[DATA_WIDTH-1] ? mul_a : '0);
            OP_MUL:    corr_res = prod_q[DATA_WIDTH-1:0];
            default:   corr_res = prod_q[DATA_WIDTH-1:0];
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q     <= OP_MUL;
            tag_q    <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            prod_q   <= '0;
            res_data <= '0;
            res_tag  <= '0;
        end else begin
            if (accept) begin
                op_q  <= req_op;
                tag_q <= req_tag;
                if (!reuse_hit) begin
                    mul_a <= req_rs1;
                    mul_b <= req_rs2;
                end
`ifdef MUL_REUSE_EN
                else begin
                    prod_q <= buf_p;
                end
`endif
            end
            if ((state_q == MULT) && !flush) begin
                prod_q <= mul_p;
            end
            if ((state_q == CORR) && !flush) begin
                res_data <= corr_res;
                res_tag  <= tag_q;
            end
        end
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: behavioural product model plus per-cycle scoreboard, directed cases and random traffic.
module tb_mul_ctrl;

`ifdef MUL_REUSE_EN
    localparam int LAT_HIT = 2;
    localparam bit REUSE   = 1'b1;
`else
    localparam int LAT_HIT = 3;
    localparam bit REUSE   = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_rs1 = '0;
    logic [31:0] req_rs2 = '0;
    logic [4:0]  req_tag = '0;
    logic        flush = 1'b0;
    logic [31:0] mul_a, mul_b;
    logic [63:0] mul_p;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [4:0]  res_tag;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mul_ctrl #(.DATA_WIDTH(32)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
        .flush(flush), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Combinational signed array the controller drives.
    assign mul_p = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (op)
            2'd2:    p = {{32{a[31]}}, a} * {32'd0, b};
            2'd3:    p = {32'd0, a} * {32'd0, b};
            default: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        endcase
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Transaction-level model: one job in flight with an edge countdown, plus the visible result.
    bit          m_vld = 1'b0;
    logic [31:0] m_dat = '0;
    logic [4:0]  m_tag = '0;
    int          m_cd = 0;
    logic [31:0] p_dat = '0;
    logic [4:0]  p_tag = '0;
    bit          p_miss = 1'b0;
    logic [31:0] p_a = '0, p_b = '0;
    bit          b_vld = 1'b0;
    logic [31:0] b_a = '0, b_b = '0;
    logic [31:0] m_a = '0, m_b = '0;
    logic        m_busy, m_rdy;

    assign m_busy = (m_cd != 0) || m_vld;
    assign m_rdy  = !RST && !flush && (!m_busy || (m_vld && res_ready));

    always @(posedge CLK) begin
        bit hit;
        if (RST) begin
            m_vld = 1'b0; m_cd = 0; b_vld = 1'b0;
            m_dat = '0; m_tag = '0; m_a = '0; m_b = '0;
        end else if (flush) begin
            m_vld = 1'b0; m_cd = 0; b_vld = 1'b0;
        end else begin
            if (m_cd != 0) begin
                if (m_cd == 2 && p_miss) begin
                    b_vld = 1'b1; b_a = p_a; b_b = p_b;
                end
                m_cd--;
                if (m_cd == 0) begin
                    m_vld = 1'b1; m_dat = p_dat; m_tag = p_tag;
                end
            end else if (m_vld && res_ready) begin
                m_vld = 1'b0;
            end
            if (req_valid && m_rdy) begin
                hit    = REUSE && b_vld && (req_rs1 == b_a) && (req_rs2 == b_b);
                p_dat  = ref_res(req_op, req_rs1, req_rs2);
                p_tag  = req_tag;
                p_miss = !hit;
                p_a    = req_rs1;
                p_b    = req_rs2;
                if (!hit) begin
                    m_a = req_rs1; m_b = req_rs2;
                end
                m_cd = hit ? 1 : 2;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("res_valid", {31'd0, res_valid}, {31'd0, m_vld});
            check("res_data", res_data, m_dat);
            check("res_tag", {27'd0, res_tag}, {27'd0, m_tag});
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("req_ready", {31'd0, req_ready}, {31'd0, m_rdy});
            check("mul_a", mul_a, m_a);
            check("mul_b", mul_b, m_b);
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        int n = 0;
        req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
        @(negedge CLK);
        while (!req_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("accept", {31'd0, req_ready}, 32'd1);
        @(posedge CLK);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        @(negedge CLK);
        while (!res_valid && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] exp, input int exp_lat);
        int lat;
        send(op, a, b, tag);
        wait_valid(lat);
        check({name, "_data"}, res_data, exp);
        check({name, "_tag"}, {27'd0, res_tag}, {27'd0, tag});
        check({name, "_lat"}, lat, exp_lat);
        @(posedge CLK);
        #1;
    endtask

    logic [31:0] pool [5];

    initial begin
        int lat;
        int nval;
        pool[0] = 32'd7; pool[1] = 32'hFFFF_FFFF; pool[2] = 32'h8000_0000; pool[3] = 32'd9; pool[4] = 32'd0;

        check("model_mul", ref_res(2'd0, 32'd5, 32'd20), 32'd100);
        check("model_mulh", ref_res(2'd1, -32'sd5, -32'sd20), 32'h0);
        check("model_mulhu", ref_res(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check("model_mulhsu", ref_res(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        check("model_mulh_min", ref_res(2'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);

        repeat (2) @(posedge CLK);
        #1 chk_en = 1'b1;
        @(negedge CLK);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0; res_ready = 1'b1;
        @(negedge CLK);
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        @(posedge CLK);
        #1;

        run_op("mul_5x20", 2'd0, 32'd5, 32'd20, 5'd7, 32'd100, 3);
        run_op("mulh_neg", 2'd1, -32'sd5, -32'sd20, 5'd1, 32'h0, 3);
        run_op("mul_neg", 2'd0, -32'sd5, -32'sd20, 5'd2, 32'h64, LAT_HIT);
        run_op("mulhu_ff", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 3);
        run_op("mulhsu_ff", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, LAT_HIT);
        run_op("mulh_min", 2'd1, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000, 3);

        // Backpressure: result held while a new request waits.
        res_ready = 1'b0;
        send(2'd0, 32'd3, 32'd11, 5'd9);
        req_valid = 1'b1; req_op = 2'd3; req_rs1 = 32'd123456; req_rs2 = 32'h8765_4321; req_tag = 5'd10;
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_data", res_data, 32'd33);
            check("bp_tag", {27'd0, res_tag}, 32'd9);
            check("bp_ready", {31'd0, req_ready}, 32'd0);
            @(negedge CLK);
        end
        @(posedge CLK);
        #1 res_ready = 1'b1;
        @(negedge CLK);
        check("bp_overlap_ready", {31'd0, req_ready}, 32'd1);
        @(posedge CLK);
        #1 req_valid = 1'b0;
        wait_valid(lat);
        check("bp_next_lat", lat, 3);
        check("bp_next_data", res_data, ref_res(2'd3, 32'd123456, 32'h8765_4321));
        @(posedge CLK);
        #1;

        // Flush during MULT.
        send(2'd0, 32'd100, 32'd200, 5'd4);
        flush = 1'b1;
        @(posedge CLK);
        #1 flush = 1'b0;
        nval = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (res_valid) nval++;
            if (i == 0) check("flush_mult_busy", {31'd0, busy}, 32'd0);
        end
        check("flush_mult_novalid", nval, 0);
        @(posedge CLK);
        #1;

        // Flush during DONE, colliding with res_ready.
        res_ready = 1'b0;
        send(2'd0, 32'd6, 32'd7, 5'd12);
        wait_valid(lat);
        @(posedge CLK);
        #1 flush = 1'b1; res_ready = 1'b1;
        @(posedge CLK);
        #1 flush = 1'b0;
        @(negedge CLK);
        check("flush_done_valid", {31'd0, res_valid}, 32'd0);
        check("flush_done_busy", {31'd0, busy}, 32'd0);
        @(posedge CLK);
        #1;
        run_op("after_flush", 2'd0, 32'd6, 32'd7, 5'd13, 32'd42, 3);

        // RST during MULT, then during DONE.
        send(2'd0, 32'd11, 32'd13, 5'd5);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("rst_mult_mul_a", mul_a, 32'd0);
        check("rst_mult_res_data", res_data, 32'd0);
        check("rst_mult_busy", {31'd0, busy}, 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0; res_ready = 1'b0;
        send(2'd0, 32'd11, 32'd13, 5'd5);
        wait_valid(lat);
        check("pre_rst_data", res_data, 32'd143);
        @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0; res_ready = 1'b1;
        @(negedge CLK);
        check("rst_done_data", res_data, 32'd0);
        check("rst_done_tag", {27'd0, res_tag}, 32'd0);
        check("rst_done_valid", {31'd0, res_valid}, 32'd0);
        @(posedge CLK);
        #1;
        run_op("after_rst", 2'd0, 32'd11, 32'd13, 5'd6, 32'd143, 3);

        // Operand reuse across MULH/MUL, and its loss after a flush.
        run_op("reuse_mulh", 2'd1, 32'd7, 32'd9, 5'd20, 32'd0, 3);
        run_op("reuse_mul", 2'd0, 32'd7, 32'd9, 5'd21, 32'd63, LAT_HIT);
        flush = 1'b1;
        @(posedge CLK);
        #1 flush = 1'b0;
        run_op("reuse_flushed", 2'd0, 32'd7, 32'd9, 5'd22, 32'd63, 3);

        // Random traffic, checked every cycle by the scoreboard.
        for (int i = 0; i < 3000; i++) begin
            @(posedge CLK);
            #1;
            req_valid = ($urandom_range(0, 9) < 6);
            req_op    = 2'($urandom_range(0, 3));
            req_rs1   = ($urandom_range(0, 3) == 0) ? $urandom() : pool[$urandom_range(0, 4)];
            req_rs2   = ($urandom_range(0, 3) == 0) ? $urandom() : pool[$urandom_range(0, 4)];
            req_tag   = 5'($urandom_range(0, 31));
            res_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 24) == 0);
            RST       = ($urandom_range(0, 149) == 0);
        end
        @(posedge CLK);
        #1 req_valid = 1'b0; flush = 1'b0; RST = 1'b0; res_ready = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
